// File: rtl/alu_muldiv_pkg.sv
// Shared operation encodings, funct7 constants and FSM states for the
// handshaked execute ALU with the iterative multiply/divide extension.
package alu_muldiv_pkg;

  typedef enum logic [2:0] {
    ADD_SUB = 3'b000,
    SLL     = 3'b001,
    SLT     = 3'b010,
    SLTU    = 3'b011,
    XOR     = 3'b100,
    SRL_SRA = 3'b101,
    OR      = 3'b110,
    AND     = 3'b111
  } alu_fn_t;

  typedef enum logic [2:0] {
    MUL    = 3'b000,
    MULH   = 3'b001,
    MULHSU = 3'b010,
    MULHU  = 3'b011,
    DIV    = 3'b100,
    DIVU   = 3'b101,
    REM    = 3'b110,
    REMU   = 3'b111
  } muldiv_fn_t;

  typedef logic [6:0] funct7_t;

  localparam funct7_t BASE    = 7'b0000000;
  localparam funct7_t SUB_SRA = 7'b0100000;
  localparam funct7_t MULDIV  = 7'b0000001;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} alu_state_t;

  // {a is signed, b is signed}; MUL takes the low half, so it can run unsigned.
  function automatic logic [1:0] muldiv_signs(logic [2:0] op);
    case (op)
      MULH, DIV, REM: muldiv_signs = 2'b11;
      MULHSU:         muldiv_signs = 2'b10;
      default:        muldiv_signs = 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative multiply/divide datapath: magnitudes in, one shift-add or
// restoring-divide step per cycle, sign fix applied to the post-step value.
module muldiv_iter
  import alu_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             step,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result
);

  // hi_reg: product high half / partial remainder; lo_reg: multiplier / dividend->quotient
  logic [WIDTH-1:0] hi_reg, lo_reg, opnd_reg;
  logic [2:0]       op_reg;
  logic             neg_q_reg, neg_r_reg;

  logic [1:0]       signs;
  logic             sa, sb;
  logic [WIDTH:0]   sum, shifted, diff;
  logic             ge;
  logic [WIDTH-1:0] hi_next, lo_next;
  logic [2*WIDTH-1:0] prod, prod_s;
  logic [WIDTH-1:0] quot, rem;

  assign signs = muldiv_signs(op);
  assign sa    = signs[1] & a[WIDTH-1];
  assign sb    = signs[0] & b[WIDTH-1];

  always_comb begin
    sum     = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, opnd_reg} : '0);
    shifted = {hi_reg, lo_reg[WIDTH-1]};
    diff    = shifted - {1'b0, opnd_reg};
    ge      = shifted >= {1'b0, opnd_reg};
    if (op_reg[2]) begin
      hi_next = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
      lo_next = {lo_reg[WIDTH-2:0], ge};
    end else begin
      hi_next = sum[WIDTH:1];
      lo_next = {sum[0], lo_reg[WIDTH-1:1]};
    end
  end

  always_comb begin
    prod   = {hi_next, lo_next};
    prod_s = neg_q_reg ? -prod : prod;
    quot   = neg_q_reg ? -lo_next : lo_next;
    rem    = neg_r_reg ? -hi_next : hi_next;
    case (op_reg)
      MUL:                result = prod_s[WIDTH-1:0];
      MULH, MULHSU, MULHU: result = prod_s[2*WIDTH-1:WIDTH];
      DIV, DIVU:          result = quot;
      default:            result = rem;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_reg    <= '0;
      lo_reg    <= '0;
      opnd_reg  <= '0;
      op_reg    <= '0;
      neg_q_reg <= 1'b0;
      neg_r_reg <= 1'b0;
    end else if (start) begin
      hi_reg    <= '0;
      lo_reg    <= sa ? -a : a;
      opnd_reg  <= sb ? -b : b;
      op_reg    <= op;
      neg_q_reg <= sa ^ sb;
      neg_r_reg <= sa;
    end else if (step) begin
      hi_reg <= hi_next;
      lo_reg <= lo_next;
    end
  end

endmodule

// File: rtl/alu_muldiv.sv
// Handshaked execute ALU: 1-cycle RV32I register ops, WIDTH-cycle RV32M ops,
// single entry with one operation in flight.
module alu_muldiv
  import alu_muldiv_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter bit MULDIV_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       fn,
  input  logic [6:0]       funct7,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_err
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  alu_state_t       state_reg, state_next;
  logic [SHW-1:0]   count_reg, count_next;
  logic [WIDTH-1:0] out_reg, out_next;
  logic             err_reg, err_next;

  logic             start, step;
  logic [WIDTH-1:0] iter_result, base_result;
  logic [SHW-1:0]   shamt;
  logic             alt, base_legal, is_m, div_zero, div_ovf;

  muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .step   (step),
    .op     (fn),
    .a      (a),
    .b      (b),
    .result (iter_result)
  );

  assign shamt      = b[SHW-1:0];
  assign alt        = (funct7 == SUB_SRA);
  assign base_legal = (funct7 == BASE) || (alt && (fn == ADD_SUB || fn == SRL_SRA));
  assign is_m       = MULDIV_EN && (funct7 == MULDIV);
  assign div_zero   = fn[2] && (b == '0);
  assign div_ovf    = (fn == DIV || fn == REM) && (a == MIN_VAL) && (b == '1);

  always_comb begin
    base_result = '0;
    case (fn)
      ADD_SUB: base_result = alt ? a - b : a + b;
      SLL:     base_result = a << shamt;
      SLT:     base_result = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      SLTU:    base_result = {{(WIDTH-1){1'b0}}, a < b};
      XOR:     base_result = a ^ b;
      SRL_SRA: begin
        // kept out of a ternary so the arithmetic shift stays signed
        if (alt) base_result = $signed(a) >>> shamt;
        else     base_result = a >> shamt;
      end
      OR:      base_result = a | b;
      AND:     base_result = a & b;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    out_next   = out_reg;
    err_next   = err_reg;
    start      = 1'b0;
    step       = 1'b0;
    case (state_reg)
      IDLE: if (in_valid) begin
        state_next = DONE;
        err_next   = 1'b0;
        if (is_m) begin
          if (div_zero)      out_next = fn[1] ? a : '1;
          else if (div_ovf)  out_next = fn[1] ? '0 : MIN_VAL;
          else begin
            start      = 1'b1;
            count_next = SHW'(WIDTH - 1);
            state_next = BUSY;
          end
        end else if (base_legal) begin
          out_next = base_result;
        end else begin
          out_next = '0;
          err_next = 1'b1;
        end
      end
      BUSY: begin
        step = 1'b1;
        if (count_reg == '0) begin
          out_next   = iter_result;
          err_next   = 1'b0;
          state_next = DONE;
        end else begin
          count_next = count_reg - 1'b1;
        end
      end
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (flush) begin
      state_next = IDLE;
      start      = 1'b0;
      step       = 1'b0;
      out_next   = out_reg;
      err_next   = err_reg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      count_reg <= '0;
      out_reg   <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      out_reg   <= out_next;
      err_reg   <= err_next;
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign out       = out_reg;
  assign out_err   = err_reg;

endmodule

// File: doc/alu_muldiv.md
Name: alu_muldiv

Overview:
- Handshaked, parametrised successor to the combinational execute ALU.
- Performs RV32I register-register ops with a 1-cycle registered result.
- Performs RV32M multiply/divide/remainder iteratively over WIDTH cycles.
- Sits in the execute stage between operand read and writeback; single-entry, one op in flight.

Parameters:
- WIDTH, 32, operand/result width in bits; power of two, minimum 4.
- MULDIV_EN, 1, 1 = M-extension ops implemented; 0 = M ops flagged illegal.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset; asynchronous assert, active-low.
- flush  input  1  synchronous kill of any op in flight or held result.
- in_valid  input  1  request valid.
- in_ready  output  1  unit can accept a request.
- fn  input  alu_fn_t (3)  funct3 operation select.
- funct7  input  funct7_t (7)  selects SUB/SRA (0100000) or M-extension (0000001).
- a  input  WIDTH  operand rs1.
- b  input  WIDTH  operand rs2.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer takes result.
- out  output  WIDTH  result.
- out_err  output  1  illegal fn/funct7 combination; out forced to 0.

Behaviour:
- Reset: state IDLE; in_ready=1; out_valid=0; out=0; out_err=0; counter and accumulators cleared.
- States:
  - IDLE: in_ready=1. On in_valid:
    - base op or special-case divide -> DONE.
    - M mul/div op -> BUSY, counter=WIDTH-1.
  - BUSY: in_ready=0. One iteration per cycle; at counter==0 finalise and go to DONE.
  - DONE: out_valid=1, out and out_err stable. On out_ready -> IDLE. No same-cycle accept in DONE.
- Latency (accept at edge N):
  - Base op: out_valid from cycle N+1.
  - Mul/div: out_valid from cycle N+WIDTH+1.
- Base ops:
  - ADD/SUB: wrap modulo 2^WIDTH.
  - SLL/SRL/SRA: shift amount = b[$clog2(WIDTH)-1:0]; SRA is arithmetic on signed a.
  - SLT: signed compare. SLTU: unsigned compare. Result 1 or 0, zero-extended.
  - AND/OR/XOR: bitwise.
- Legal funct7 values:
  - 0000000: all base ops.
  - 0100000: ADD_SUB and SRL_SRA only.
  - 0000001: M ops, only when MULDIV_EN=1.
  - Anything else: out_err=1, out=0, 1-cycle latency.
- Multiply:
  - Shift-add on operand magnitudes into a 2*WIDTH product.
  - Sign fixed at finalisation per signedness: MULH s*s, MULHSU s*u, MULHU u*u.
  - MUL returns the low half; the MULH variants return the high half.
- Divide:
  - Restoring division on magnitudes, one quotient bit per cycle.
  - Signed results: quotient sign = sign(a)^sign(b); remainder sign = sign(a).
- Special cases, resolved at accept with 1-cycle latency:
  - b==0: DIV/DIVU -> all ones; REM/REMU -> a.
  - Signed overflow (a=MIN, b=-1): DIV -> MIN; REM -> 0.
- Operands are captured at accept; a and b may change afterwards.
- Flush: any state -> IDLE next edge, out_valid=0, result discarded. Flush in the same cycle as an IDLE accept wins; the request is dropped.
- Async reset mid-BUSY aborts immediately with no output.
- out_valid held with out_ready=0: out/out_err stable indefinitely.

Decomposition:
- Shared package ALU_FNS gains:
  - M-extension funct3 enum muldiv_fn_t.
  - funct7 constant MULDIV = 7'b0000001, alongside SUB_SRA.
  - State enum alu_state_t {IDLE, BUSY, DONE}.
- Sub-module muldiv_iter (WIDTH): iterative datapath (magnitude conversion, shift-add/restoring loop, sign fix).
- The top module holds the FSM, handshake, base-op logic and special-case detection.

Test Plan:
- ADD_SUB funct7=0100000, a=5, b=7 -> out=0xFFFFFFFE one cycle after accept. SLT a=-1, b=1 -> 1. SLTU, same operands -> 0.
- MULH a=0x80000000, b=0x80000000 -> out=0x40000000 at cycle N+33. MULHSU a=-1, b=0xFFFFFFFF -> 0xFFFFFFFF.
- DIV a=-7, b=2 -> -3; REM -> -1. DIVU a=7, b=0 -> 0xFFFFFFFF at N+1. DIV a=0x80000000, b=-1 -> 0x80000000.
- Hold out_ready=0 for 10 cycles after a MUL 6*7 -> out=42 stable and in_ready=0 throughout; accept resumes the cycle after out_ready.
- flush at BUSY cycle 10 of a DIVU -> out_valid never rises and in_ready=1 next cycle. A new ADD then completes correctly.
- funct7=0100000 with fn=AND, or MULDIV_EN=0 with an M op -> out_err=1, out=0.
